mem_interface: RTL

- Downstream stage of the cache system: consumes the `nmcu_pkg::mem_req_t` stream that the cache forwards and returns `nmcu_pkg::mem_resp_t` to it.
- Buffers requests in a small in-order FIFO and services them one at a time against an on-chip word-addressed memory array with fixed, parameterised access latency.
- Serves as the NMCU's main-memory model and as the future attach point for an external memory bridge.

---
 rtl/nmcu_pkg.sv | 28 ++
 rtl/mem_req_fifo.sv | 63 ++++++
 rtl/mem_interface.sv | 118 +++++++++++
 3 files changed

// File: rtl/nmcu_pkg.sv
// Shared types for the NMCU cache/memory path: request/response structs
// and the memory-interface FSM state encoding.
package nmcu_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic              ready;
    logic              valid;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } mem_resp_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mif_state_e;

endpackage

// File: rtl/mem_req_fifo.sv
// In-order request queue for mem_interface. Pointers carry one wrap bit so
// full and empty are distinguishable; the full flag is registered.
module mem_req_fifo
  import nmcu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  mem_req_t din,
  output mem_req_t dout,
  output logic     full,
  output logic     empty
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]  PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  mem_req_t       slot_r [DEPTH];
  logic [PTR_W:0] wr_ptr_r;
  logic [PTR_W:0] rd_ptr_r;
  logic [PTR_W:0] wr_nxt_s;
  logic [PTR_W:0] rd_nxt_s;
  logic           full_r;
  logic           full_nxt_s;
  logic           do_push_s;
  logic           do_pop_s;

  // A push while full is dropped even if a pop happens in the same cycle.
  assign do_push_s  = push && !full_r;
  assign do_pop_s   = pop && !empty;
  assign wr_nxt_s   = do_push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
  assign rd_nxt_s   = do_pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
  assign full_nxt_s = (wr_nxt_s[PTR_W] != rd_nxt_s[PTR_W]) &&
                      (wr_nxt_s[PTR_W-1:0] == rd_nxt_s[PTR_W-1:0]);

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = full_r;
  assign dout  = slot_r[rd_ptr_r[PTR_W-1:0]];

  // Entry storage, written on accepted push
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      slot_r[wr_ptr_r[PTR_W-1:0]] <= din;
    end
  end

  // Pointer and full-flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      full_r   <= 1'b0;
    end else begin
      wr_ptr_r <= wr_nxt_s;
      rd_ptr_r <= rd_nxt_s;
      full_r   <= full_nxt_s;
    end
  end

endmodule

// File: rtl/mem_interface.sv
// Main-memory model for the NMCU: queues cache requests and services them
// one at a time against an on-chip word array with fixed latency LAT.
module mem_interface
  import nmcu_pkg::*;
#(
  parameter int MEM_WORDS  = 1024,
  parameter int LAT        = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  mem_req_t  req_i,
  output mem_resp_t resp_o
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  mif_state_e        state_r;
  mif_state_e        state_nxt_s;
  logic [3:0]        lat_cnt_r;
  logic [3:0]        lat_cnt_nxt_s;
  mem_req_t          op_r;
  mem_req_t          head_s;
  logic [DATA_W-1:0] array_r [MEM_WORDS];
  logic              run_r;
  logic              ready_s;
  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic              access_s;
  logic              in_range_s;
  logic [IDX_W-1:0]  idx_s;
  logic              resp_valid_r;
  logic              resp_err_r;
  logic [DATA_W-1:0] resp_rdata_r;

  // run_r keeps ready low until the first edge after reset release.
  assign ready_s    = run_r && !full_s;
  assign push_s     = req_i.valid && ready_s;
  assign in_range_s = op_r.valid && (op_r.addr < ADDR_W'(MEM_WORDS));
  assign idx_s      = op_r.addr[IDX_W-1:0];

  mem_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (req_i),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Next-state logic: pop in IDLE or RESP, count down in ACCESS
  always_comb begin
    state_nxt_s   = state_r;
    lat_cnt_nxt_s = lat_cnt_r;
    pop_s         = 1'b0;
    access_s      = 1'b0;
    case (state_r)
      IDLE, RESP: begin
        if (!empty_s) begin
          pop_s         = 1'b1;
          state_nxt_s   = ACCESS;
          lat_cnt_nxt_s = 4'(LAT - 1);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        if (lat_cnt_r == 4'd0) begin
          access_s    = 1'b1;
          state_nxt_s = RESP;
        end else begin
          lat_cnt_nxt_s = lat_cnt_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM, op and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      lat_cnt_r    <= 4'd0;
      op_r         <= '0;
      run_r        <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= '0;
    end else begin
      state_r      <= state_nxt_s;
      lat_cnt_r    <= lat_cnt_nxt_s;
      run_r        <= 1'b1;
      if (pop_s) begin
        op_r <= head_s;
      end
      resp_valid_r <= access_s;
      resp_err_r   <= access_s && !in_range_s;
      resp_rdata_r <= (access_s && in_range_s && !op_r.we) ? array_r[idx_s] : '0;
    end
  end

  // Array write; out-of-range writes never touch the array
  always_ff @(posedge clk) begin
    if (access_s && in_range_s && op_r.we) begin
      array_r[idx_s] <= op_r.wdata;
    end
  end

  assign resp_o = '{ready: ready_s, valid: resp_valid_r,
                    err: resp_err_r, rdata: resp_rdata_r};

endmodule
